// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================
// adc_pkg : shared types for the 24-bit ADC acquisition path
// Rev 1.0
// ============================================================
package adc_pkg;

   localparam int ADC_BITS   = 24;
   localparam int EDGE_CNT_W = $clog2(ADC_BITS + 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CONVERT   = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_SHIFT     = 3'd3,
      ST_DELIVER   = 3'd4
   } state_e;

   typedef logic [ADC_BITS-1:0] frame_t;

endpackage
`default_nettype wire

// File: rtl/adc_sck_gen.sv
`default_nettype none
// ============================================================
// adc_sck_gen : SCK divider, rising-edge strobe and edge counter
// Rev 1.0
// ============================================================
module adc_sck_gen
   import adc_pkg::*;
#(
   parameter int SCK_HALF = 2
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   output logic sck_o,
   output logic rise_o,
   output logic done_o
);

   localparam int DIV_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

   logic [DIV_W-1:0]      div_q, div_d;
   logic                  sck_q, sck_d;
   logic [EDGE_CNT_W-1:0] edges_q, edges_d;
   logic                  half_end;

   always_comb begin
      half_end = (div_q == DIV_W'(SCK_HALF - 1));
      rise_o   = en_i && half_end && !sck_q && (edges_q < EDGE_CNT_W'(ADC_BITS));
      // done coincides with the falling edge that follows the last rise
      done_o   = en_i && half_end && sck_q && (edges_q == EDGE_CNT_W'(ADC_BITS));
      div_d    = div_q;
      sck_d    = sck_q;
      edges_d  = edges_q;
      if (!en_i) begin
         div_d   = '0;
         sck_d   = 1'b0;
         edges_d = '0;
      end else if (half_end) begin
         div_d = '0;
         sck_d = sck_q ? 1'b0 : rise_o;
         if (rise_o) begin
            edges_d = edges_q + 1'b1;
         end
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q   <= '0;
         sck_q   <= 1'b0;
         edges_q <= '0;
      end else begin
         div_q   <= div_d;
         sck_q   <= sck_d;
         edges_q <= edges_d;
      end
   end

   assign sck_o = sck_q;

endmodule
`default_nettype wire

// File: rtl/adc_acq_controller.sv
`default_nettype none
// ============================================================
// adc_acq_controller : periodic CNV / BUSY / 24-bit SPI readout sequencer
// Rev 1.0
// ============================================================
module adc_acq_controller
   import adc_pkg::*;
#(
   parameter int CLK_FREQ     = 100_000_000,
   parameter int SMPL_FREQ    = 48_000,
   parameter int SCK_HALF     = 2,
   parameter int CNV_HIGH     = 4,
   parameter int BUSY_TIMEOUT = 1024
)
(
   input  logic                clk,
   input  logic                i_reset_n,
   input  logic                i_enable,
   input  logic                i_clr_status,
   input  logic                i_busy,
   input  logic                i_data_in,
   output logic                o_cnv,
   output logic                o_sck,
   output logic                o_rdl_sdi,
   output logic                o_chain,
   output logic [ADC_BITS-1:0] o_data,
   output logic                o_valid,
   input  logic                i_ready,
   output logic                o_overrun,
   output logic                o_timeout
);

   localparam int PERIOD = CLK_FREQ / SMPL_FREQ;
   localparam int TICK_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int CNV_W  = (CNV_HIGH > 1) ? $clog2(CNV_HIGH) : 1;
   localparam int TO_W   = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

   state_e            state_q, state_d;
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic              busy_s1_q, busy_s2_q;
   logic [CNV_W-1:0]  cnv_cnt_q, cnv_cnt_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              seen_q, seen_d;
   frame_t            shift_q, shift_d;
   frame_t            data_q, data_d;
   logic              valid_q, valid_d;
   logic              cnv_q, cnv_d;
   logic              ovr_q, ovr_d;
   logic              tmo_q, tmo_d;
   logic              tick, ovr_set, tmo_set;
   logic              sck_en, sck_rise, sck_done;

   adc_sck_gen #(.SCK_HALF(SCK_HALF)) u_sck_gen (
      .clk   (clk),
      .rst_n (i_reset_n),
      .en_i  (sck_en),
      .sck_o (o_sck),
      .rise_o(sck_rise),
      .done_o(sck_done)
   );

   assign sck_en = i_enable && (state_q == ST_SHIFT);

   always_comb begin
      tick       = i_enable && (tick_cnt_q == TICK_W'(PERIOD - 1));
      tick_cnt_d = (!i_enable || tick) ? '0 : tick_cnt_q + 1'b1;
      state_d    = state_q;
      cnv_cnt_d  = cnv_cnt_q;
      to_cnt_d   = to_cnt_q;
      seen_d     = seen_q;
      shift_d    = shift_q;
      data_d     = data_q;
      valid_d    = valid_q;
      tmo_set    = 1'b0;
      // a tick that lands mid-frame is dropped and only flagged
      ovr_set    = tick && (state_q != ST_IDLE);

      if (!i_enable) begin
         state_d   = ST_IDLE;
         cnv_cnt_d = '0;
         to_cnt_d  = '0;
         seen_d    = 1'b0;
         valid_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (tick) begin
                  state_d   = ST_CONVERT;
                  cnv_cnt_d = '0;
               end
            end
            ST_CONVERT: begin
               if (cnv_cnt_q == CNV_W'(CNV_HIGH - 1)) begin
                  state_d   = ST_WAIT_BUSY;
                  cnv_cnt_d = '0;
                  to_cnt_d  = '0;
                  seen_d    = 1'b0;
               end else begin
                  cnv_cnt_d = cnv_cnt_q + 1'b1;
               end
            end
            ST_WAIT_BUSY: begin
               if (seen_q && !busy_s2_q) begin
                  state_d  = ST_SHIFT;
                  to_cnt_d = '0;
               end else if (to_cnt_q == TO_W'(BUSY_TIMEOUT - 1)) begin
                  state_d  = ST_IDLE;
                  to_cnt_d = '0;
                  tmo_set  = 1'b1;
               end else begin
                  to_cnt_d = to_cnt_q + 1'b1;
                  if (busy_s2_q) begin
                     seen_d = 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               if (sck_rise) begin
                  shift_d = {shift_q[ADC_BITS-2:0], i_data_in};
               end
               if (sck_done) begin
                  state_d = ST_DELIVER;
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end
            end
            ST_DELIVER: begin
               if (i_ready && valid_q) begin
                  state_d = ST_IDLE;
                  valid_d = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      cnv_d = (state_d == ST_CONVERT);
      ovr_d = ovr_set || (ovr_q && !i_clr_status);
      tmo_d = tmo_set || (tmo_q && !i_clr_status);
   end

   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= ST_IDLE;
         tick_cnt_q <= '0;
         busy_s1_q  <= 1'b1;
         busy_s2_q  <= 1'b1;
         cnv_cnt_q  <= '0;
         to_cnt_q   <= '0;
         seen_q     <= 1'b0;
         shift_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         cnv_q      <= 1'b0;
         ovr_q      <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         busy_s1_q  <= i_busy;
         busy_s2_q  <= busy_s1_q;
         cnv_cnt_q  <= cnv_cnt_d;
         to_cnt_q   <= to_cnt_d;
         seen_q     <= seen_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         cnv_q      <= cnv_d;
         ovr_q      <= ovr_d;
         tmo_q      <= tmo_d;
      end
   end

   assign o_cnv     = cnv_q;
   assign o_data    = data_q;
   assign o_valid   = valid_q;
   assign o_overrun = ovr_q;
   assign o_timeout = tmo_q;
   assign o_rdl_sdi = 1'b0;
   assign o_chain   = 1'b0;

endmodule
`default_nettype wire
